seq_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_addsub.sv | 22 ++
 rtl/seq_alu.sv | 162 ++++++++++++++++
 tb/tb_seq_alu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execution-stage ALU:
// operation codes, FSM state encoding and the signed-overflow helper.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Subtraction is addition of ~b, so overflow means the effective operands
    // share a sign and the sum's sign differs from it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic sum_msb, input logic sub);
        logic b_eff;
        b_eff = b_msb ^ sub;
        return (a_msb == b_eff) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
// Produces the modulo-2^WIDTH sum, carry-out and signed overflow.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    assign ovf_o = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sum_o[WIDTH-1], sub_i);

endmodule

// File: rtl/seq_alu.sv
// Execution-stage ALU: single-cycle logic/arithmetic ops, serial one-bit-per-cycle SLL.
// Handshake: start is sampled only while busy=0; every accepted request yields exactly one done pulse.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   shamt;
    logic             is_sll;
    logic             sub_sel;
    logic             serial_start;
    logic             last_shift;
    logic [WIDTH-1:0] sh_next;

    logic [WIDTH-1:0] sum;
    logic             carry_unused;
    logic             add_ovf;

    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

    assign shamt        = b[SHW-1:0];
    assign is_sll       = (alu_ctr == ALU_SLL);
    assign sub_sel      = (alu_ctr == ALU_SUB) || (alu_ctr == ALU_SLT);
    assign serial_start = (state_q == ST_IDLE) && start && is_sll && (shamt != {SHW{1'b0}});
    assign last_shift   = (state_q == ST_SHIFT) && (cnt_q == SHW'(1));
    assign sh_next      = sh_q << 1;

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i    (a),
        .b_i    (b),
        .sub_i  (sub_sel),
        .sum_o  (sum),
        .carry_o(carry_unused),
        .ovf_o  (add_ovf)
    );

    // SLL with a zero shift amount falls through to the single-cycle path as result=a.
    always_comb begin
        op_res = a;
        op_ovf = 1'b0;
        case (alu_ctr)
            ALU_AND: op_res = a & b;
            ALU_OR:  op_res = a | b;
            ALU_XOR: op_res = a ^ b;
            ALU_NOR: op_res = ~(a | b);
            ALU_ADD: begin
                op_res = sum;
                op_ovf = add_ovf;
            end
            ALU_SUB: begin
                op_res = sum;
                op_ovf = add_ovf;
            end
            ALU_SLT: op_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: op_res = a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (serial_start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_sll) begin
                        sh_d  = a;
                        cnt_d = shamt;
                    end
                    if (!serial_start) begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        ovf_d    = op_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - SHW'(1);
                if (last_shift) begin
                    result_d = sh_next;
                    zero_d   = (sh_next == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                sh_d  = sh_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

    a_ctrl_known : assert property (@(posedge clk) disable iff (reset)
        !busy |-> !$isunknown({start, alu_ctr}));

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a driver pushes the hand-computed response per accepted
// request and a done-triggered monitor pops and compares it.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   alu_ctr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_ctr (alu_ctr),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!reset && done) begin
            got = {result, zero, overflow};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h with no request outstanding", result);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL done_result: got res=%h z=%b ov=%b expected res=%h z=%b ov=%b",
                             got.res, got.z, got.ov, e.res, e.z, e.ov);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic eo, input bit push);
        exp_t e;
        alu_ctr = op;
        a       = x;
        b       = y;
        start   = 1'b1;
        if (push) begin
            e.res = er;
            e.z   = (er == '0);
            e.ov  = eo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the start edge; latency counts edges including the start edge.
    task automatic wait_done(input string name, input int exp_lat, input int exp_busy,
                             input bit inject, input logic [W-1:0] held);
        int lat;
        int bcnt;
        bit moved;
        lat   = 1;
        bcnt  = 0;
        moved = 1'b0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (result !== held) moved = 1'b1;
            if (inject) begin
                start   = 1'($urandom_range(0, 1));
                alu_ctr = 3'($urandom_range(0, 7));
                a       = $urandom;
                b       = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({name, "_latency"}, W'(lat), W'(exp_lat));
        check({name, "_busy_cycles"}, W'(bcnt), W'(exp_busy));
        if (exp_busy > 0) check({name, "_result_held"}, W'(moved), '0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_result"}, result, '0);
        check({name, "_zero"}, W'(zero), W'(1));
        check({name, "_overflow"}, W'(overflow), '0);
        check({name, "_busy"}, W'(busy), '0);
        check({name, "_done"}, W'(done), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        alu_ctr = ALU_AND;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        wait_done("add", 1, 0, 1'b0, '0);
        issue(ALU_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
        issue(ALU_ADD, 32'd3, 32'hFFFFFFFD, 32'h0, 1'b0, 1'b1);
        issue(ALU_SLT, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 1'b1);
        issue(ALU_SLT, 32'd1, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b1);
        issue(ALU_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        issue(ALU_OR, 32'hF0, 32'h3C, 32'hFC, 1'b0, 1'b1);
        issue(ALU_XOR, 32'hF0, 32'h3C, 32'hCC, 1'b0, 1'b1);
        issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b1);
        issue(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
        issue(ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
        issue(ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
        issue(ALU_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1);

        issue(ALU_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b1);
        wait_done("sll31", 32, 31, 1'b1, 32'h7FFFFFFF);
        repeat (3) @(posedge clk);
        #1;

        issue(ALU_SLL, 32'hA5, 32'd0, 32'hA5, 1'b0, 1'b1);
        check("sll0_done_now", W'(done), W'(1));
        issue(ALU_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b1);
        check("and_b2b_done", W'(done), W'(1));
        @(posedge clk);
        #1;

        issue(ALU_SLL, 32'd5, 32'hFFFFFFE4, 32'h50, 1'b0, 1'b1);
        wait_done("sll4", 5, 4, 1'b0, 32'h30);
        @(posedge clk);
        #1;

        issue(ALU_SLL, 32'd1, 32'd10, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_shift_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("post_reset_busy", W'(busy), '0);

        issue(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b1);
        wait_done("add_after_reset", 1, 0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
